// File: rtl/aes_key_sched_ctrl_if.sv
// rtl/aes_key_sched_ctrl_if.sv - key-schedule controller bus: command, round_key_tf link, read port
interface aes_key_sched_ctrl_if;
    logic         start_i;
    logic [127:0] key_i;
    logic         key_clear_i;
    logic         ready_o;
    logic         done_o;
    logic         keys_valid_o;
    logic         tf_start_o;
    logic [127:0] tf_key_o;
    logic [3:0]   tf_round_o;
    logic [127:0] tf_key_i;
    logic         tf_done_i;
    logic         rd_en_i;
    logic [3:0]   rd_idx_i;
    logic [127:0] rd_key_o;
    logic         rd_valid_o;
    logic         rd_err_o;

    modport slave (
        input  start_i, key_i, key_clear_i, tf_key_i, tf_done_i, rd_en_i, rd_idx_i,
        output ready_o, done_o, keys_valid_o, tf_start_o, tf_key_o, tf_round_o,
               rd_key_o, rd_valid_o, rd_err_o
    );

    modport master (
        output start_i, key_i, key_clear_i, tf_key_i, tf_done_i, rd_en_i, rd_idx_i,
        input  ready_o, done_o, keys_valid_o, tf_start_o, tf_key_o, tf_round_o,
               rd_key_o, rd_valid_o, rd_err_o
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - drives round_key_tf NR times and serves the round-key bank
module aes_key_sched_ctrl #(
    parameter int NR      = 10,
    parameter bit ZEROIZE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_key_sched_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR - 1);
    localparam logic [3:0] LAST_SLOT  = 4'(NR);

    state_t        state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [127:0]  tf_key_q, tf_key_d;
    logic          keys_valid_q, keys_valid_d;
    logic          done_q, done_d;
    logic          tf_start_q, tf_start_d;

    logic [127:0]  rd_key_q;
    logic          rd_valid_q;
    logic          rd_err_q;

    logic [127:0]  bank_q [0:NR];
    logic          bank_we;
    logic [3:0]    bank_widx;
    logic [127:0]  bank_wdata;
    logic          rd_legal;

    // Pulses are registered off the next state so they line up exactly with ISSUE / the IDLE return.
    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        tf_key_d     = tf_key_q;
        keys_valid_d = keys_valid_q;
        done_d       = 1'b0;
        tf_start_d   = 1'b0;
        bank_we      = 1'b0;
        bank_widx    = 4'd0;
        bank_wdata   = '0;

        if (bus.key_clear_i) begin
            state_d      = IDLE;
            round_d      = 4'd0;
            keys_valid_d = 1'b0;
            if (ZEROIZE) begin
                tf_key_d = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        bank_we      = 1'b1;
                        bank_widx    = 4'd0;
                        bank_wdata   = bus.key_i;
                        tf_key_d     = bus.key_i;
                        round_d      = 4'd0;
                        keys_valid_d = 1'b0;
                        tf_start_d   = 1'b1;
                        state_d      = ISSUE;
                    end
                end
                ISSUE: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (bus.tf_done_i) begin
                        bank_we    = 1'b1;
                        bank_widx  = round_q + 4'd1;
                        bank_wdata = bus.tf_key_i;
                        tf_key_d   = bus.tf_key_i;
                        if (round_q == LAST_ROUND) begin
                            keys_valid_d = 1'b1;
                            done_d       = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            round_d    = round_q + 4'd1;
                            tf_start_d = 1'b1;
                            state_d    = ISSUE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    round_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            round_q      <= 4'd0;
            tf_key_q     <= '0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
            tf_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            tf_key_q     <= tf_key_d;
            keys_valid_q <= keys_valid_d;
            done_q       <= done_d;
            tf_start_q   <= tf_start_d;
        end
    end

    // Key storage is deliberately left out of reset; only an explicit clear wipes it.
    always_ff @(posedge clk) begin
        if (bus.key_clear_i && ZEROIZE) begin
            for (int i = 0; i <= NR; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bank_we) begin
            bank_q[bank_widx] <= bank_wdata;
        end
    end

    assign rd_legal = (bus.rd_idx_i <= LAST_SLOT) && keys_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en_i;
            if (bus.rd_en_i) begin
                if (rd_legal) begin
                    rd_key_q <= bank_q[bus.rd_idx_i];
                    rd_err_q <= 1'b0;
                end else begin
                    rd_key_q <= '0;
                    rd_err_q <= 1'b1;
                end
            end else begin
                rd_err_q <= 1'b0;
            end
        end
    end

    assign bus.ready_o      = (state_q == IDLE);
    assign bus.done_o       = done_q;
    assign bus.keys_valid_o = keys_valid_q;
    assign bus.tf_start_o   = tf_start_q;
    assign bus.tf_key_o     = tf_key_q;
    assign bus.tf_round_o   = round_q;
    assign bus.rd_key_o     = rd_key_q;
    assign bus.rd_valid_o   = rd_valid_q;
    assign bus.rd_err_o     = rd_err_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - directed bench for aes_key_sched_ctrl with a round_key_tf stand-in
module tb_aes_key_sched_ctrl;
    logic clk;
    logic rst_n;

    aes_key_sched_ctrl_if bus ();

    aes_key_sched_ctrl #(.NR(10), .ZEROIZE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic         en;
        logic [3:0]   idx;
        logic         exp_valid;
        logic         exp_err;
        logic [127:0] exp_key;
    } rd_vec_t;

    logic [127:0] exp_rk [0:10];
    rd_vec_t      vecs [0:15];
    int tests;
    int fails;
    int n_starts;
    int epoch;
    int lat;
    logic glitch;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {127'd0, act}, {127'd0, exp});
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        chk(nm, {96'd0, act}, {96'd0, exp});
    endtask

    // Stand-in for round_key_tf: answers each tf_start_o after lat cycles with the FIPS-197 next key.
    initial begin : tf_model
        int   cnt;
        int   rnd;
        int   seen_epoch;
        int   nxt;
        logic pend;
        pend = 1'b0; cnt = 0; rnd = 0; seen_epoch = -1; nxt = 0;
        n_starts = 0;
        bus.tf_done_i = 1'b0;
        bus.tf_key_i  = '0;
        forever begin
            @(negedge clk);
            bus.tf_done_i = 1'b0;
            if (pend && !bus.ready_o) begin
                chki("tf_round_hold", int'(bus.tf_round_o), rnd);
                chk("tf_key_hold", bus.tf_key_o, exp_rk[rnd]);
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.tf_done_i = 1'b1;
                    bus.tf_key_i  = exp_rk[rnd + 1];
                    pend = 1'b0;
                end
            end
            if (bus.tf_start_o) begin
                if (seen_epoch != epoch) begin
                    seen_epoch = epoch;
                    nxt = 0;
                end
                chki("tf_round_step", int'(bus.tf_round_o), nxt);
                chk("tf_key_at_start", bus.tf_key_o, exp_rk[bus.tf_round_o]);
                nxt++;
                rnd = int'(bus.tf_round_o);
                cnt = lat;
                pend = 1'b1;
                n_starts++;
                if (glitch) begin
                    bus.tf_done_i = 1'b1;
                    bus.tf_key_i  = {4{32'hdeadbeef}};
                end
            end
        end
    end

    task automatic run_expansion(input int lat_in, input int hold, input int rd_cyc, output int done_cyc);
        lat = lat_in;
        epoch++;
        done_cyc = -1;
        bus.start_i = 1'b1;
        bus.key_i   = exp_rk[0];
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (rd_cyc != 0 && cyc == rd_cyc + 1) begin
                chkb("last_slot_same_cycle_valid", bus.rd_valid_o, 1'b1);
                chkb("last_slot_same_cycle_err", bus.rd_err_o, 1'b1);
                chk("last_slot_same_cycle_key", bus.rd_key_o, '0);
                bus.rd_en_i = 1'b0;
            end
            if (rd_cyc != 0 && cyc == rd_cyc) begin
                bus.rd_en_i  = 1'b1;
                bus.rd_idx_i = 4'd10;
            end
            if (bus.done_o) begin
                done_cyc = cyc;
                break;
            end
            chkb("ready_low_busy", bus.ready_o, 1'b0);
            if (cyc >= hold) bus.start_i = 1'b0;
        end
        bus.start_i = 1'b0;
        if (done_cyc < 0) chki("expansion_timeout", done_cyc, 0);
    endtask

    task automatic rd_chk(input logic [3:0] idx, input logic exp_err, input logic [127:0] exp_key);
        bus.rd_en_i  = 1'b1;
        bus.rd_idx_i = idx;
        @(negedge clk);
        bus.rd_en_i = 1'b0;
        chkb("rd_valid", bus.rd_valid_o, 1'b1);
        chkb("rd_err", bus.rd_err_o, exp_err);
        chk("rd_key", bus.rd_key_o, exp_key);
    endtask

    task automatic post_done_checks();
        @(negedge clk);
        chkb("done_one_cycle", bus.done_o, 1'b0);
        chkb("keys_valid_after", bus.keys_valid_o, 1'b1);
        chkb("ready_after", bus.ready_o, 1'b1);
    endtask

    initial begin : main
        int dc;
        int s0;
        int ok;
        exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) vecs[i] = '{1'b1, 4'(i), 1'b1, 1'b0, exp_rk[i]};
        vecs[11] = '{1'b0, 4'd3,  1'b0, 1'b0, exp_rk[10]};
        vecs[12] = '{1'b1, 4'd11, 1'b1, 1'b1, 128'd0};
        vecs[13] = '{1'b1, 4'd15, 1'b1, 1'b1, 128'd0};
        vecs[14] = '{1'b1, 4'd5,  1'b1, 1'b0, exp_rk[5]};
        vecs[15] = '{1'b0, 4'd0,  1'b0, 1'b0, exp_rk[5]};

        tests = 0; fails = 0; epoch = 0; lat = 3; glitch = 1'b0;
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.key_i = '0; bus.key_clear_i = 1'b0;
        bus.rd_en_i = 1'b0; bus.rd_idx_i = '0;
        repeat (2) @(negedge clk);
        chkb("rst_ready", bus.ready_o, 1'b1);
        chkb("rst_done", bus.done_o, 1'b0);
        chkb("rst_keys_valid", bus.keys_valid_o, 1'b0);
        chkb("rst_tf_start", bus.tf_start_o, 1'b0);
        chk("rst_tf_key", bus.tf_key_o, '0);
        chki("rst_tf_round", int'(bus.tf_round_o), 0);
        chk("rst_rd_key", bus.rd_key_o, '0);
        chkb("rst_rd_valid", bus.rd_valid_o, 1'b0);
        chkb("rst_rd_err", bus.rd_err_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 expansion with L=3, then back-to-back table reads
        s0 = n_starts;
        run_expansion(3, 1, 0, dc);
        chki("done_latency_L3", dc, 41);
        chki("tf_start_count_L3", n_starts - s0, 10);
        post_done_checks();
        bus.rd_en_i  = vecs[0].en;
        bus.rd_idx_i = vecs[0].idx;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chkb($sformatf("vec%0d_valid", i), bus.rd_valid_o, vecs[i].exp_valid);
            chkb($sformatf("vec%0d_err", i), bus.rd_err_o, vecs[i].exp_err);
            chk($sformatf("vec%0d_key", i), bus.rd_key_o, vecs[i].exp_key);
            if (i < 15) begin
                bus.rd_en_i  = vecs[i + 1].en;
                bus.rd_idx_i = vecs[i + 1].idx;
            end else begin
                bus.rd_en_i = 1'b0;
            end
        end

        // start_i held while busy, tf_done_i glitch in ISSUE, read of final slot in its write cycle
        glitch = 1'b1;
        s0 = n_starts;
        run_expansion(3, 30, 40, dc);
        glitch = 1'b0;
        chki("done_latency_hold", dc, 41);
        post_done_checks();
        repeat (4) @(negedge clk);
        chki("tf_start_count_hold", n_starts - s0, 10);
        for (int i = 0; i <= 10; i++) rd_chk(4'(i), 1'b0, exp_rk[i]);

        // minimum latency boundary
        s0 = n_starts;
        run_expansion(1, 1, 0, dc);
        chki("done_latency_L1", dc, 21);
        chki("tf_start_count_L1", n_starts - s0, 10);
        post_done_checks();

        // key_clear_i during round 4
        lat = 3;
        epoch++;
        bus.start_i = 1'b1;
        bus.key_i   = exp_rk[0];
        @(negedge clk);
        bus.start_i = 1'b0;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus.tf_round_o == 4'd4 && !bus.tf_start_o) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chki("reach_round4", ok, 1);
        bus.key_clear_i = 1'b1;
        @(negedge clk);
        bus.key_clear_i = 1'b0;
        chkb("clr_ready", bus.ready_o, 1'b1);
        chkb("clr_keys_valid", bus.keys_valid_o, 1'b0);
        chkb("clr_tf_start", bus.tf_start_o, 1'b0);
        chk("clr_tf_key", bus.tf_key_o, '0);
        chki("clr_tf_round", int'(bus.tf_round_o), 0);
        rd_chk(4'd0, 1'b1, '0);
        repeat (5) @(negedge clk);
        s0 = n_starts;
        bus.start_i = 1'b1;
        bus.key_clear_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.key_clear_i = 1'b0;
        repeat (4) @(negedge clk);
        chkb("clr_beats_start_ready", bus.ready_o, 1'b1);
        chki("clr_beats_start_count", n_starts - s0, 0);
        run_expansion(2, 1, 0, dc);
        chki("done_latency_after_clear", dc, 31);
        post_done_checks();
        rd_chk(4'd1, 1'b0, exp_rk[1]);
        rd_chk(4'd10, 1'b0, exp_rk[10]);

        // asynchronous reset during WAIT
        lat = 3;
        epoch++;
        bus.start_i = 1'b1;
        bus.key_i   = exp_rk[0];
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (6) @(negedge clk);
        chkb("pre_rst_busy", bus.ready_o, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chkb("arst_ready", bus.ready_o, 1'b1);
        chkb("arst_keys_valid", bus.keys_valid_o, 1'b0);
        chkb("arst_tf_start", bus.tf_start_o, 1'b0);
        chk("arst_tf_key", bus.tf_key_o, '0);
        chki("arst_tf_round", int'(bus.tf_round_o), 0);
        chk("arst_rd_key", bus.rd_key_o, '0);
        chkb("arst_rd_valid", bus.rd_valid_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_starts;
        repeat (10) @(negedge clk);
        chki("arst_no_restart", n_starts - s0, 0);
        chkb("arst_idle_ready", bus.ready_o, 1'b1);
        chkb("arst_done_low", bus.done_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
